// File: rtl/issue_scoreboard_if.sv
// rtl/issue_scoreboard_if.sv - decode/writeback request bundle and interlock response for issue_scoreboard
interface issue_scoreboard_if #(
    parameter int NREG  = 32,
    parameter int LAT_W = 4
) ();
    logic             flush;
    logic             u_valid;
    logic [2:0]       u_use;
    logic [4:0]       u_src_a;
    logic [4:0]       u_src_b;
    logic [4:0]       u_src_s;
    logic             u_dst_en;
    logic [4:0]       u_dst;
    logic [LAT_W-1:0] u_lat;
    logic             l_valid;
    logic [2:0]       l_use;
    logic [4:0]       l_src_a;
    logic [4:0]       l_src_b;
    logic [4:0]       l_src_s;
    logic             l_dst_en;
    logic [4:0]       l_dst;
    logic [LAT_W-1:0] l_lat;
    logic             clr_valid;
    logic [4:0]       clr_rd;
    logic             interlock;
    logic [NREG-1:0]  busy_o;

    modport master (
        output flush,
        output u_valid, u_use, u_src_a, u_src_b, u_src_s, u_dst_en, u_dst, u_lat,
        output l_valid, l_use, l_src_a, l_src_b, l_src_s, l_dst_en, l_dst, l_lat,
        output clr_valid, clr_rd,
        input  interlock, busy_o
    );

    modport slave (
        input  flush,
        input  u_valid, u_use, u_src_a, u_src_b, u_src_s, u_dst_en, u_dst, u_lat,
        input  l_valid, l_use, l_src_a, l_src_b, l_src_s, l_dst_en, l_dst, l_lat,
        input  clr_valid, clr_rd,
        output interlock, busy_o
    );
endinterface

// File: rtl/issue_scoreboard.sv
// rtl/issue_scoreboard.sv - GPR pending-write scoreboard and dual-issue interlock (optional SCOREBOARD_PERF_EN stall counter)
module issue_scoreboard #(
    parameter int NREG  = 32,
    parameter int LAT_W = 4
) (
    input  logic                 clk,
    input  logic                 rstn,
    issue_scoreboard_if.slave    sb
`ifdef SCOREBOARD_PERF_EN
    ,
    output logic [31:0]          stall_cycles
`endif
);
    // All-ones latency marks an entry that only a writeback clear can release.
    localparam logic [LAT_W-1:0] FROZEN  = '1;
    localparam logic [LAT_W-1:0] CNT_ONE = LAT_W'(1);

    logic [NREG-1:0]  busy_q, busy_d;
    logic [LAT_W-1:0] cnt_q [NREG];
    logic [LAT_W-1:0] cnt_d [NREG];

    logic u_hit, l_hit, pair_hit, interlock_c, issue;

    function automatic logic slot_hit(
        input logic [NREG-1:0] busy,
        input logic            valid,
        input logic [2:0]      use_m,
        input logic [4:0]      a,
        input logic [4:0]      b,
        input logic [4:0]      s,
        input logic            dst_en,
        input logic [4:0]      dst
    );
        return valid & ((use_m[0] & busy[a]) | (use_m[1] & busy[b]) |
                        (use_m[2] & busy[s]) | (dst_en & busy[dst]));
    endfunction

    // Hazards against registered state plus the intra-pair RAW/WAW checks.
    always_comb begin
        u_hit = slot_hit(busy_q, sb.u_valid, sb.u_use, sb.u_src_a, sb.u_src_b,
                         sb.u_src_s, sb.u_dst_en, sb.u_dst);
        l_hit = slot_hit(busy_q, sb.l_valid, sb.l_use, sb.l_src_a, sb.l_src_b,
                         sb.l_src_s, sb.l_dst_en, sb.l_dst);
        pair_hit = sb.u_valid & sb.u_dst_en & sb.l_valid &
                   ((sb.l_use[0] & (sb.l_src_a == sb.u_dst)) |
                    (sb.l_use[1] & (sb.l_src_b == sb.u_dst)) |
                    (sb.l_use[2] & (sb.l_src_s == sb.u_dst)) |
                    (sb.l_dst_en & (sb.l_dst == sb.u_dst)));
        interlock_c = rstn & (u_hit | l_hit | pair_hit);
        issue       = (sb.u_valid | sb.l_valid) & ~interlock_c & ~sb.flush;
    end

    assign sb.interlock = interlock_c;
    assign sb.busy_o    = busy_q;

    // Next scoreboard state: countdown, then writeback clear, then new issues.
    always_comb begin
        busy_d = busy_q;
        for (int r = 0; r < NREG; r++) begin
            cnt_d[r] = cnt_q[r];
            if (busy_q[r] && (cnt_q[r] != FROZEN)) begin
                cnt_d[r] = cnt_q[r] - CNT_ONE;
                if (cnt_q[r] == CNT_ONE) begin
                    busy_d[r] = 1'b0;
                end
            end
        end
        if (sb.clr_valid) begin
            busy_d[sb.clr_rd] = 1'b0;
            cnt_d[sb.clr_rd]  = '0;
        end
        // Issue cannot collide with a clear of a busy register: WAW already stalled it.
        if (issue && sb.u_valid && sb.u_dst_en && (sb.u_lat != '0)) begin
            busy_d[sb.u_dst] = 1'b1;
            cnt_d[sb.u_dst]  = sb.u_lat;
        end
        if (issue && sb.l_valid && sb.l_dst_en && (sb.l_lat != '0)) begin
            busy_d[sb.l_dst] = 1'b1;
            cnt_d[sb.l_dst]  = sb.l_lat;
        end
    end

    // Scoreboard state registers; reset discards all pending entries.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            busy_q <= '0;
            for (int r = 0; r < NREG; r++) begin
                cnt_q[r] <= '0;
            end
        end else begin
            busy_q <= busy_d;
            for (int r = 0; r < NREG; r++) begin
                cnt_q[r] <= cnt_d[r];
            end
        end
    end

`ifdef SCOREBOARD_PERF_EN
    logic [31:0] stall_q, stall_d;

    // Count real stall cycles (flushed cycles are not stalls), saturating.
    always_comb begin
        stall_d = stall_q;
        if (interlock_c && !sb.flush && (stall_q != 32'hFFFF_FFFF)) begin
            stall_d = stall_q + 32'd1;
        end
    end

    // Stall counter register.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            stall_q <= '0;
        end else begin
            stall_q <= stall_d;
        end
    end

    assign stall_cycles = stall_q;
`endif
endmodule
